// File: rtl/reg_share_pkg.sv
// Shared types and defaults for the round-robin register-sharing arbiter.
package reg_share_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int DATA_W_DEF   = 3;
  localparam int MAX_HOLD_DEF = 8;
  localparam int MAX_REQ      = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Requester-side bus of the shared register: requests, lock, write data and grant/ack/q status.
interface reg_share_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 3
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       q;
  logic                    busy;

  modport master (output req, lock, wdata, input gnt, ack, q, busy);
  modport slave  (input req, lock, wdata, output gnt, ack, q, busy);
endinterface

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from start_i upward, wrapping at N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    start_i,
  output logic             valid_o,
  output logic [IW-1:0]    idx_o,
  output logic [N_REQ-1:0] onehot_o
);

  localparam logic [IW:0] N_EXT = (IW+1)'(N_REQ);

  logic [N_REQ-1:0] rot;
  logic [IW-1:0]    offset;
  logic [IW:0]      sum;

  // rot[k] is the request seen k positions after the start pointer
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [IW:0] raw;
    logic [IW:0] wrapped;
    assign raw     = {1'b0, start_i} + (IW+1)'(gi);
    assign wrapped = (raw >= N_EXT) ? raw - N_EXT : raw;
    assign rot[gi] = req_i[wrapped[IW-1:0]];
  end

  always_comb begin
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) offset = IW'(i);
    end
  end

  assign sum     = {1'b0, start_i} + {1'b0, offset};
  assign idx_o   = (sum >= N_EXT) ? IW'(sum - N_EXT) : sum[IW-1:0];
  assign valid_o = |req_i;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_oh
    assign onehot_o[gi] = valid_o && (idx_o == IW'(gi));
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin owner of one shared DATA_W-bit register; the granted requester writes it and gets a one-cycle ack.
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic                 clk,
  input logic                 resetn,
  reg_share_arbiter_if.slave  bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  state_t             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   ack_q;
  logic [DATA_W-1:0]  data_q;
  logic               busy_q;
  logic [IW-1:0]      last_q;
  logic [HW-1:0]      hold_cnt_q;

  logic [IW-1:0]      start_d;
  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic [N_REQ-1:0]   pick_oh;
  logic [N_REQ-1:0]   owner_mask;
  logic               others_pending;
  logic               hold_sat;
  logic               keep_d;
  logic [DATA_W-1:0]  wslice [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign wslice[gi] = bus.wdata[gi*DATA_W +: DATA_W];
  end

  // In OWN the last winner is the owner, so one pointer serves both IDLE and hand-off scans
  assign start_d = (last_q == IW'(N_REQ - 1)) ? '0 : last_q + 1'b1;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req_i    (bus.req),
    .start_i  (start_d),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx),
    .onehot_o (pick_oh)
  );

  assign owner_mask     = N_REQ'(onehot(32'(last_q)));
  assign others_pending = |(bus.req & ~owner_mask);
  assign hold_sat       = (hold_cnt_q >= HW'(MAX_HOLD));
  assign keep_d         = (|(bus.req & bus.lock & owner_mask)) && !(hold_sat && others_pending);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      hold_cnt_q <= '0;
      last_q     <= IW'(N_REQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q    <= OWN;
            gnt_q      <= pick_oh;
            ack_q      <= pick_oh;
            data_q     <= wslice[pick_idx];
            busy_q     <= 1'b1;
            last_q     <= pick_idx;
            hold_cnt_q <= HW'(1);
          end else begin
            ack_q <= '0;
          end
        end
        OWN: begin
          if (keep_d) begin
            data_q <= wslice[last_q];
            ack_q  <= gnt_q;
            if (!hold_sat) hold_cnt_q <= hold_cnt_q + 1'b1;
          end else if (pick_valid) begin
            // Hand-off on the same edge: the scan starts past the owner, so it is considered last
            gnt_q      <= pick_oh;
            ack_q      <= pick_oh;
            data_q     <= wslice[pick_idx];
            last_q     <= pick_idx;
            hold_cnt_q <= HW'(1);
          end else begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.ack  = ack_q;
  assign bus.q    = data_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed self-checking bench for reg_share_arbiter (N_REQ=4, DATA_W=3, MAX_HOLD=8).
module tb_reg_share_arbiter;

  localparam int N_REQ    = 4;
  localparam int DATA_W   = 3;
  localparam int MAX_HOLD = 8;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;

  reg_share_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  reg_share_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [3:0] a,
                           input logic [2:0] qq, input logic b);
    check_eq({tag, " gnt"},  32'(bus.gnt),  32'(g));
    check_eq({tag, " ack"},  32'(bus.ack),  32'(a));
    check_eq({tag, " q"},    32'(bus.q),    32'(qq));
    check_eq({tag, " busy"}, 32'(bus.busy), 32'(b));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    resetn    = 1'b0;
    bus.req   = '0;
    bus.lock  = '0;
    bus.wdata = '0;

    // Reset state
    step();
    check_out("reset", 4'b0000, 4'b0000, 3'd0, 1'b0);
    resetn = 1'b1;

    // Single request; non-selected wdata is X and must not reach q
    bus.req   = 4'b0001;
    bus.wdata = {3'bxxx, 3'bxxx, 3'bxxx, 3'b101};
    step();
    check_out("single grant", 4'b0001, 4'b0001, 3'b101, 1'b1);
    bus.req = 4'b0000;
    step();
    check_out("single release", 4'b0000, 4'b0000, 3'b101, 1'b0);

    // Fresh priority, then all four requesting without lock: rotate 0,1,2,3,0
    resetn = 1'b0;
    #1;
    resetn    = 1'b1;
    bus.req   = 4'b1111;
    bus.lock  = 4'b0000;
    bus.wdata = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int k = 0; k < 5; k++) begin
      step();
      check_out($sformatf("rr k=%0d", k), 4'(1 << (k % 4)), 4'(1 << (k % 4)),
                3'((k % 4) + 1), 1'b1);
    end
    bus.req = 4'b0000;
    step();
    check_out("rr idle", 4'b0000, 4'b0000, 3'd1, 1'b0);

    // Locked owner 0 alone for 20 cycles: q follows wdata0 with one-cycle lag
    bus.req  = 4'b0001;
    bus.lock = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      bus.wdata = {3'd4, 3'd3, 3'd2, 3'((k + 3) % 8)};
      step();
      check_out($sformatf("lock k=%0d", k), 4'b0001, 4'b0001, 3'((k + 3) % 8), 1'b1);
    end
    bus.req  = 4'b0000;
    bus.lock = 4'b0000;
    step();
    check_out("lock idle", 4'b0000, 4'b0000, 3'd6, 1'b0);

    // Forced release after MAX_HOLD owned cycles with requester 2 pending from cycle 4
    bus.req   = 4'b0001;
    bus.lock  = 4'b0001;
    bus.wdata = {3'd0, 3'd6, 3'd0, 3'd1};
    for (int k = 1; k <= MAX_HOLD; k++) begin
      if (k == 4) bus.req = 4'b0101;
      step();
      check_eq($sformatf("hold owned=%0d gnt", k), 32'(bus.gnt), 32'h1);
    end
    step();
    check_out("forced release", 4'b0100, 4'b0100, 3'd6, 1'b1);
    bus.lock = 4'b0101;
    step();
    check_eq("owner2 kept 1 gnt", 32'(bus.gnt), 32'h4);
    step();
    check_eq("owner2 kept 2 gnt", 32'(bus.gnt), 32'h4);
    bus.req  = 4'b0001;
    bus.lock = 4'b0001;
    step();
    check_out("regrant 0", 4'b0001, 4'b0001, 3'd1, 1'b1);

    // Owner 1 releases with req=0101: hand-off scans from 2, no idle cycle
    bus.req  = 4'b0000;
    bus.lock = 4'b0000;
    step();
    check_eq("pre-handoff idle busy", 32'(bus.busy), 32'h0);
    bus.req   = 4'b0010;
    bus.lock  = 4'b0010;
    bus.wdata = {3'd0, 3'b110, 3'd3, 3'd1};
    step();
    check_out("owner 1", 4'b0010, 4'b0010, 3'd3, 1'b1);
    bus.req  = 4'b0101;
    bus.lock = 4'b0000;
    step();
    check_out("handoff to 2", 4'b0100, 4'b0100, 3'b110, 1'b1);

    // Asynchronous reset mid-ownership clears outputs before any clock edge
    resetn = 1'b0;
    #1;
    check_out("async reset", 4'b0000, 4'b0000, 3'd0, 1'b0);
    #2;
    resetn    = 1'b1;
    bus.req   = 4'b1111;
    bus.wdata = {3'd7, 3'd6, 3'd2, 3'd5};
    step();
    check_out("post-reset grant", 4'b0001, 4'b0001, 3'd5, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
